// File: rtl/unidad_control_multiciclo.sv
// Multicycle main control FSM for the MIPS-subset datapath.
// Moore decode of every datapath mux/enable from the registered state; pc_write in BRANCH and ext_op/alu_op in I_EXEC also look at inputs.
module unidad_control_multiciclo #(
  localparam int unsigned OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                pc_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_op,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          estado
);

  localparam int unsigned STATE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    INICIO    = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    I_EXEC    = 4'd11,
    I_WB      = 4'd12
  } state_t;

  state_t state_q, state_d;

  // State register; reset forces INICIO at once so no pending write survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INICIO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = INICIO;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    ext_op     = 1'b1;
    alu_op     = ALU_ADD;
    pc_source  = PCSRC_ALU;
    estado     = STATE_W'(state_q);

    unique case (state_q)
      INICIO: begin
        ext_op  = 1'b0;
        state_d = FETCH;
      end
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:             state_d = MEM_ADDR;
          OP_RTYPE:                 state_d = R_EXEC;
          OP_BEQ:                   state_d = BRANCH;
          OP_J:                     state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = I_EXEC;
          default:                  state_d = FETCH;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW:   state_d = MEM_READ;
          OP_SW:   state_d = MEM_WRITE;
          default: state_d = FETCH;
        endcase
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = zero;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_d   = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        // Logical immediates zero-extend and take their ALU function from the opcode.
        if (opcode == OP_ANDI || opcode == OP_ORI) begin
          alu_op = ALU_LOGIC;
          ext_op = 1'b0;
        end
        state_d = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      default: begin
        ext_op  = 1'b0;
        state_d = INICIO;
      end
    endcase
  end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench for unidad_control_multiciclo: expected per-cycle state and control word queued per instruction.
module tb_unidad_control_multiciclo;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk, reset, zero;
  logic [5:0] opcode;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] estado;
  logic [15:0] ctrl;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  op;
    logic        z;
    logic [15:0] ctrl;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  unidad_control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .pc_source(pc_source), .estado(estado)
  );

  assign ctrl = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, ext_op, alu_op, pc_source};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word per state, straight from the state/output table.
  function automatic logic [15:0] model_ctrl(input logic [3:0] st, input logic [5:0] op, input logic z);
    logic pcw, io, mr, mw, irw, rd, m2r, rw, asa, eo;
    logic [1:0] asb, aop, pcs;
    {pcw, io, mr, mw, irw, rd, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00; eo = 1'b1;
    case (st)
      4'd0:  eo = 1'b0;
      4'd1:  begin mr = 1'b1; irw = 1'b1; asb = 2'b01; pcw = 1'b1; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1'b1; asb = 2'b10; end
      4'd4:  begin mr = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; end
      4'd7:  begin asa = 1'b1; aop = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pcw = z; end
      4'd10: begin pcs = 2'b10; pcw = 1'b1; end
      4'd11: begin
        asa = 1'b1; asb = 2'b10;
        if (op == OP_ADDI) begin aop = 2'b00; eo = 1'b1; end
        else begin aop = 2'b11; eo = 1'b0; end
      end
      4'd12: rw = 1'b1;
      default: eo = 1'b0;
    endcase
    return {pcw, io, mr, mw, irw, rd, m2r, rw, asa, asb, eo, aop, pcs};
  endfunction

  task automatic push_state(input logic [3:0] st, input logic [5:0] op, input logic z);
    exp_t x;
    x.st = st; x.op = op; x.z = z; x.ctrl = model_ctrl(st, op, z);
    sb_q.push_back(x);
  endtask

  // Queue the full state walk for one instruction starting at FETCH.
  task automatic push_instr(input logic [5:0] op, input logic z);
    push_state(4'd1, op, z);
    push_state(4'd2, op, z);
    case (op)
      OP_LW:    begin push_state(4'd3, op, z); push_state(4'd4, op, z); push_state(4'd5, op, z); end
      OP_SW:    begin push_state(4'd3, op, z); push_state(4'd6, op, z); end
      OP_RTYPE: begin push_state(4'd7, op, z); push_state(4'd8, op, z); end
      OP_BEQ:   push_state(4'd9, op, z);
      OP_J:     push_state(4'd10, op, z);
      OP_ADDI, OP_ANDI, OP_ORI: begin push_state(4'd11, op, z); push_state(4'd12, op, z); end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = OP_BAD; zero = 1'b1;
    @(negedge clk);
    checks++;
    if (estado !== 4'd0 || ctrl !== 16'h0) begin
      errors++; $display("FAIL reset_hold: estado=%0d ctrl=%h, expected estado=0 ctrl=0000", estado, ctrl);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (estado !== 4'd0 || ctrl !== 16'h0) begin
      errors++; $display("FAIL reset_release: estado=%0d ctrl=%h, expected estado=0 ctrl=0000", estado, ctrl);
    end
    push_instr(OP_LW, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (estado !== e.st || ctrl !== e.ctrl) begin
        errors++; $display("FAIL reset_lw: estado=%0d ctrl=%h, expected estado=%0d ctrl=%h", estado, ctrl, e.st, e.ctrl);
      end
      if (e.st == 4'd1) begin opcode = e.op; zero = e.z; end
    end
    sb_q.delete();
    reset = 1'b1;
    #1;
    checks++;
    if (estado !== 4'd0 || ctrl !== 16'h0) begin
      errors++; $display("FAIL reset_async: estado=%0d ctrl=%h, expected estado=0 ctrl=0000", estado, ctrl);
    end
    @(negedge clk);
    checks++;
    if (estado !== 4'd0 || ctrl !== 16'h0) begin
      errors++; $display("FAIL reset_mid_hold: estado=%0d ctrl=%h, expected estado=0 ctrl=0000", estado, ctrl);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (estado !== 4'd0 || ctrl !== 16'h0) begin
      errors++; $display("FAIL reset_mid_release: estado=%0d ctrl=%h, expected estado=0 ctrl=0000", estado, ctrl);
    end
  endtask

  task automatic test_lw();
    push_instr(OP_LW, 1'b0);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (estado !== e.st || ctrl !== e.ctrl) begin
        errors++; $display("FAIL lw: estado=%0d ctrl=%h, expected estado=%0d ctrl=%h", estado, ctrl, e.st, e.ctrl);
      end
      if (e.st == 4'd1) begin opcode = e.op; zero = e.z; end
    end
  endtask

  task automatic test_beq();
    push_instr(OP_BEQ, 1'b1);
    push_instr(OP_BEQ, 1'b0);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (estado !== e.st || ctrl !== e.ctrl) begin
        errors++; $display("FAIL beq: estado=%0d ctrl=%h, expected estado=%0d ctrl=%h", estado, ctrl, e.st, e.ctrl);
      end
      if (e.st == 4'd1) begin opcode = e.op; zero = e.z; end
    end
  endtask

  task automatic test_imm();
    push_instr(OP_ORI, 1'b1);
    push_instr(OP_ADDI, 1'b0);
    push_instr(OP_ANDI, 1'b0);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (estado !== e.st || ctrl !== e.ctrl) begin
        errors++; $display("FAIL imm: estado=%0d ctrl=%h, expected estado=%0d ctrl=%h", estado, ctrl, e.st, e.ctrl);
      end
      if (e.st == 4'd1) begin opcode = e.op; zero = e.z; end
    end
  endtask

  task automatic test_jump();
    push_instr(OP_J, 1'b0);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (estado !== e.st || ctrl !== e.ctrl) begin
        errors++; $display("FAIL jump: estado=%0d ctrl=%h, expected estado=%0d ctrl=%h", estado, ctrl, e.st, e.ctrl);
      end
      if (e.st == 4'd1) begin opcode = e.op; zero = e.z; end
    end
  endtask

  task automatic test_back_to_back();
    push_instr(OP_RTYPE, 1'b1);
    push_instr(OP_SW, 1'b1);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (estado !== e.st || ctrl !== e.ctrl) begin
        errors++; $display("FAIL b2b: estado=%0d ctrl=%h, expected estado=%0d ctrl=%h", estado, ctrl, e.st, e.ctrl);
      end
      if (e.st == 4'd1) begin opcode = e.op; zero = e.z; end
    end
  endtask

  task automatic test_unknown();
    push_instr(OP_BAD, 1'b1);
    push_instr(OP_J, 1'b0);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (estado !== e.st || ctrl !== e.ctrl) begin
        errors++; $display("FAIL unknown: estado=%0d ctrl=%h, expected estado=%0d ctrl=%h", estado, ctrl, e.st, e.ctrl);
      end
      if (e.st == 4'd1) begin opcode = e.op; zero = e.z; end
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; zero = 1'b0;
    test_reset();
    test_lw();
    test_beq();
    test_imm();
    test_jump();
    test_back_to_back();
    test_unknown();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
